// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard unit: load-use stall, branch flush, store-data forwarding flag and halt draining.
// Controls are combinational from state and current inputs; only state, drain count and stall count are registered.
module id_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       id_src0_addr,
  input  logic [3:0]       id_src1_addr,
  input  logic             id_src0_used,
  input  logic             id_src1_used,
  input  logic             id_store,
  input  logic             id_hlt,
  input  logic [3:0]       ex_dst_addr,
  input  logic             ex_we,
  input  logic             ex_mem_re,
  input  logic             br_taken,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             lw_stall,
  output logic             mem_hazard,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [DW-1:0] drain_cnt;

  logic ex_load;
  logic ld_match_0;
  logic ld_match_1;
  logic load_use;
  logic store_fwd;

  // R0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign ex_load    = ex_mem_re & ex_we;
  assign ld_match_0 = ex_load & (ex_dst_addr == id_src0_addr) & (id_src0_addr != 4'd0);
  assign ld_match_1 = ex_load & (ex_dst_addr == id_src1_addr) & (id_src1_addr != 4'd0);

  // Store data from a load is forwarded in MEM, so src1 of a store never stalls.
  assign load_use  = (id_src0_used & ld_match_0) | (id_src1_used & ld_match_1 & ~id_store);
  assign store_fwd = id_store & id_src1_used & ld_match_1;

  assign mem_hazard = store_fwd & ~br_taken;
  assign halted     = (state == HALTED);

  always_comb begin
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    lw_stall    = 1'b0;
    state_nxt   = state;
    case (state)
      RUN: begin
        if (br_taken) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
          lw_stall    = 1'b1;
        end else if (id_hlt) begin
          stall_pc    = 1'b1;
          flush_if_id = 1'b1;
          state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = HALTED;
        end
      end
      HALTED: begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Drain count is held at zero in RUN so DRAIN always starts from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt + DW'(1);
    end else begin
      drain_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && load_use && !br_taken && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed-vector bench for id_hazard_ctrl with a scoreboard queue checked at each falling edge.
module tb_id_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] id_src0_addr;
  logic [3:0] id_src1_addr;
  logic       id_src0_used;
  logic       id_src1_used;
  logic       id_store;
  logic       id_hlt;
  logic [3:0] ex_dst_addr;
  logic       ex_we;
  logic       ex_mem_re;
  logic       br_taken;
  logic       stall_pc;
  logic       stall_if_id;
  logic       flush_if_id;
  logic       flush_id_ex;
  logic       lw_stall;
  logic       mem_hazard;
  logic       halted;
  logic [3:0] stall_cnt;

  id_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_src0_addr (id_src0_addr),
    .id_src1_addr (id_src1_addr),
    .id_src0_used (id_src0_used),
    .id_src1_used (id_src1_used),
    .id_store     (id_store),
    .id_hlt       (id_hlt),
    .ex_dst_addr  (ex_dst_addr),
    .ex_we        (ex_we),
    .ex_mem_re    (ex_mem_re),
    .br_taken     (br_taken),
    .stall_pc     (stall_pc),
    .stall_if_id  (stall_if_id),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .lw_stall     (lw_stall),
    .mem_hazard   (mem_hazard),
    .halted       (halted),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: stall_pc, stall_if_id, flush_if_id, flush_id_ex, lw_stall, mem_hazard, halted
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1101100;
  localparam logic [6:0] BR   = 7'b0011000;
  localparam logic [6:0] HL   = 7'b1010000;
  localparam logic [6:0] HD   = 7'b1010001;
  localparam logic [6:0] HDM  = 7'b1010011;
  localparam logic [6:0] MH   = 7'b0000010;

  string       name_q[$];
  logic [10:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [10:0] e;
      logic [10:0] a;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {stall_pc, stall_if_id, flush_if_id, flush_id_ex, lw_stall, mem_hazard, halted, stall_cnt};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got flags=%b cnt=%0d, want flags=%b cnt=%0d",
                 n, a[10:4], a[3:0], e[10:4], e[3:0]);
      end
    end
  end

  task automatic vec(input string nm, input logic rst,
                     input logic [3:0] s0, input logic [3:0] s1,
                     input logic u0, input logic u1, input logic st, input logic hlt,
                     input logic [3:0] dst, input logic we, input logic re, input logic br,
                     input logic [6:0] exp_f, input logic [3:0] exp_c);
    @(posedge clk);
    #1;
    rst_n        = rst;
    id_src0_addr = s0;
    id_src1_addr = s1;
    id_src0_used = u0;
    id_src1_used = u1;
    id_store     = st;
    id_hlt       = hlt;
    ex_dst_addr  = dst;
    ex_we        = we;
    ex_mem_re    = re;
    br_taken     = br;
    name_q.push_back(nm);
    exp_q.push_back({exp_f, exp_c});
  endtask

  initial begin
    rst_n = 1'b0;
    id_src0_addr = 4'd0; id_src1_addr = 4'd0; id_src0_used = 1'b0; id_src1_used = 1'b0;
    id_store = 1'b0; id_hlt = 1'b0; ex_dst_addr = 4'd0; ex_we = 1'b0; ex_mem_re = 1'b0;
    br_taken = 1'b0;

    //        name          rst s0 s1 u0 u1 st hl dst we re br  flags cnt
    vec("reset",            0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 4'd0);
    vec("idle_after_rst",   1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 4'd0);
    vec("load_use_src0",    1,  3, 0, 1, 0, 0, 0, 3, 1, 1, 0, LU,   4'd0);
    vec("one_bubble",       1,  3, 0, 1, 0, 0, 0, 0, 0, 0, 0, NONE, 4'd1);
    vec("r0_no_stall",      1,  0, 0, 1, 0, 0, 0, 0, 1, 1, 0, NONE, 4'd1);
    vec("alu_no_stall",     1,  3, 0, 1, 0, 0, 0, 3, 1, 0, 0, NONE, 4'd1);
    vec("store_fwd",        1,  2, 5, 1, 1, 1, 0, 5, 1, 1, 0, MH,   4'd1);
    vec("load_use_src1",    1,  0, 7, 0, 1, 0, 0, 7, 1, 1, 0, LU,   4'd1);
    vec("br_priority",      1,  3, 3, 1, 1, 1, 1, 3, 1, 1, 1, BR,   4'd2);
    vec("run_after_br",     1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 4'd2);
    vec("hlt_in_run",       1,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, HL,   4'd2);
    vec("drain_0",          1,  4, 0, 1, 0, 0, 1, 4, 1, 1, 1, HL,   4'd2);
    vec("drain_1",          1,  4, 0, 1, 0, 0, 0, 4, 1, 1, 0, HL,   4'd2);
    vec("drain_2",          1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, HL,   4'd2);
    vec("halted_br",        1,  6, 0, 1, 0, 0, 1, 6, 1, 1, 1, HD,   4'd2);
    vec("halted_memhz",     1,  1, 6, 1, 1, 1, 0, 6, 1, 1, 0, HDM,  4'd2);
    vec("halted_idle",      1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, HD,   4'd2);
    vec("async_rst",        0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 4'd0);
    vec("run_after_rst",    1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 4'd0);

    for (int i = 0; i < 20; i++) begin
      vec("saturate",       1,  9, 0, 1, 0, 0, 0, 9, 1, 1, 0, LU,   (i > 15) ? 4'd15 : 4'(i));
    end
    vec("sat_hold",         1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 4'd15);

    for (int k = 0; k < 50 && exp_q.size() > 0; k++) begin
      @(posedge clk);
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
